conv_window_generator: RTL and testbench

Producer side of the convolution stage's window interface. It accepts a raster-order pixel stream (one pixel per handshake) for an ImageWidth x ImageWidth image and emits one zero-padded ("same") N x N window per pixel, in raster order of window centre. The output word matches the stage's in_data format, and the stage's out_ready drives this block's out_ready. Internally it holds an N-row ring line buffer and a registered output slot with a valid/ready handshake.

---
 rtl/conv_pkg.sv | 11 +
 rtl/conv_window_generator_if.sv | 11 +
 rtl/conv_line_ring.sv | 28 ++
 rtl/conv_window_generator.sv | 79 +++++++
 tb/tb_conv_window_generator.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/conv_pkg.sv
// conv_pkg: shared state type, default geometry and window-availability helper
package conv_pkg;
  typedef enum logic [1:0] {S_FILL, S_RUN, S_DRAIN} state_t;
  localparam int DEF_N = 3;
  localparam int DEF_W = 4;
  localparam int P = (DEF_N - 1) / 2;
  localparam int FRAME = DEF_W * DEF_W;
  function automatic int win_need(input int r, input int c, input int w, input int p);
    return ((r + p < w - 1) ? r + p : w - 1) * w + ((c + p < w - 1) ? c + p : w - 1) + 1;
  endfunction
endpackage

// File: rtl/conv_window_generator_if.sv
// conv_window_generator_if: pixel-in / window-out handshake bundle
interface conv_window_generator_if #(
  parameter int N = 3,
  parameter int BitSize = 32
);
  logic in_valid, in_ready, out_ready, out_valid, out_last;
  logic [BitSize-1:0] in_data;
  logic [N*N*BitSize-1:0] out_data;
  modport master (input in_valid, in_data, out_ready, output in_ready, out_valid, out_data, out_last);
  modport slave (output in_valid, in_data, out_ready, input in_ready, out_valid, out_data, out_last);
endinterface

// File: rtl/conv_line_ring.sv
// conv_line_ring: N-row ring of image lines with a zero-filled NxN gather around (row, col)
module conv_line_ring #(
  parameter int N = 3,
  parameter int BitSize = 32,
  parameter int W = 4
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(N*W)-1:0]   i_waddr,
  input  logic [BitSize-1:0]       i_wdata,
  input  int                       i_row,
  input  int                       i_col,
  output logic [N*N*BitSize-1:0]   o_win
);
  localparam int P = (N - 1) / 2;
  localparam int AW = $clog2(N * W);
  logic [BitSize-1:0] r_mem [N*W];
  always_ff @(posedge clk)
    if (i_we) r_mem[i_waddr] <= i_wdata;
  // image row rr lives in ring row rr mod N
  always_comb begin
    o_win = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        if (i_row + i >= P && i_row + i - P < W && i_col + j >= P && i_col + j - P < W)
          o_win[(i*N+j)*BitSize +: BitSize] = r_mem[AW'(((i_row + i - P) % N) * W + i_col + j - P)];
  end
endmodule

// File: rtl/conv_window_generator.sv
// conv_window_generator: emits one zero-padded NxN window per raster pixel
// through a registered output slot with valid/ready handshake
module conv_window_generator
  import conv_pkg::*;
#(
  parameter int N = 3,
  parameter int BitSize = 32,
  parameter int ImageWidth = 4
) (
  input logic clk,
  input logic res_n,
  conv_window_generator_if.master bus
);
  localparam int W = ImageWidth;
  localparam int PD = (N - 1) / 2;
  localparam int FR = W * W;
  localparam int CW = $clog2(FR + 1);
  localparam int AW = $clog2(N * W);
  state_t r_state;
  logic [CW-1:0] r_in_count, r_out_count;
  logic r_valid, r_last;
  logic [N*N*BitSize-1:0] r_data, w_win;
  int w_in_row, w_out_row, w_c;
  logic w_in_ready, w_acc, w_load;
  // a new row may only overwrite a ring row no pending window still needs
  always_comb begin
    w_in_row = int'(r_in_count) / W;
    w_out_row = int'(r_out_count) / W;
    w_c = int'(r_out_count) % W;
    w_in_ready = r_state != S_DRAIN && int'(r_in_count) < FR && (w_in_row < N || w_in_row <= w_out_row + PD);
    w_acc = bus.in_valid && w_in_ready;
    w_load = int'(r_out_count) < FR && int'(r_in_count) >= win_need(w_out_row, w_c, W, PD) && (!r_valid || bus.out_ready);
  end
  conv_line_ring #(.N(N), .BitSize(BitSize), .W(W)) u_ring (
    .clk(clk),
    .i_we(w_acc),
    .i_waddr(AW'(int'(r_in_count) % (N * W))),
    .i_wdata(bus.in_data),
    .i_row(w_out_row),
    .i_col(w_c),
    .o_win(w_win)
  );
  assign bus.in_ready = w_in_ready;
  assign bus.out_valid = r_valid;
  assign bus.out_data = r_data;
  assign bus.out_last = r_last;
  always_ff @(posedge clk) begin
    if (!res_n) begin
      r_state <= S_FILL;
      r_in_count <= '0;
      r_out_count <= '0;
      r_valid <= 1'b0;
      r_last <= 1'b0;
      r_data <= '0;
    end else begin
      if (w_acc) r_in_count <= r_in_count + 1'b1;
      if (w_load) begin
        r_data <= w_win;
        r_valid <= 1'b1;
        r_last <= int'(r_out_count) == FR - 1;
        r_out_count <= r_out_count + 1'b1;
      end else if (r_valid && bus.out_ready) begin
        r_valid <= 1'b0;
        r_last <= 1'b0;
      end
      case (r_state)
        S_FILL: if (w_load) r_state <= S_RUN;
        S_RUN: if (int'(r_in_count) == FR) r_state <= S_DRAIN;
        S_DRAIN:
          if (r_valid && bus.out_ready && r_last) begin
            r_state <= S_FILL;
            r_in_count <= '0;
            r_out_count <= '0;
          end
        default: r_state <= S_FILL;
      endcase
    end
  end
endmodule

// File: tb/tb_conv_window_generator.sv
// tb_conv_window_generator: directed window table plus a scoreboard against a
// zero-padded reference, covering stalls, back-to-back frames and resets
module tb_conv_window_generator;
  localparam int N = 3, BS = 8, W = 4, NW = W * W, WB = N * N * BS;
  logic clk = 1'b0, res_n = 1'b0;
  always #5 clk = ~clk;
  conv_window_generator_if #(.N(N), .BitSize(BS)) bus();
  conv_window_generator #(.N(N), .BitSize(BS), .ImageWidth(W)) dut (.clk(clk), .res_n(res_n), .bus(bus));
  typedef struct { int idx; logic [WB-1:0] win; logic last; } vec_t;
  vec_t tbl[5];
  logic [WB-1:0] got_win[NW];
  logic got_last[NW];
  logic [WB-1:0] prev_data = '0;
  int n_vec = 0, n_bad = 0;
  int in_frame = -1, out_frame = -1, in_k = 0, out_w = 0, frames_done = 0, cap_frame = 0;
  int vprob = 100, rprob = 100;
  logic pend = 1'b0, prev_stall = 1'b0, after_last = 1'b0, seen_first = 1'b0, chk_first = 1'b0;

  function automatic logic [BS-1:0] pix(input int f, input int k);
    return BS'(f * NW + k + 1);
  endfunction

  function automatic logic [WB-1:0] gold(input int f, input int w);
    logic [WB-1:0] g;
    int rr, cc;
    g = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        rr = w / W + i - 1;
        cc = w % W + j - 1;
        if (rr >= 0 && rr < W && cc >= 0 && cc < W) g[(i*N+j)*BS +: BS] = pix(f, rr * W + cc);
      end
    return g;
  endfunction

  function automatic logic [WB-1:0] w9(input int a, b, c, d, e, f, g, h, i);
    return {8'(i), 8'(h), 8'(g), 8'(f), 8'(e), 8'(d), 8'(c), 8'(b), 8'(a)};
  endfunction

  task automatic chk(input string nm, input logic [WB-1:0] act, input logic [WB-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    logic ih, oh;
    @(negedge clk);
    if (!pend) bus.in_valid = $urandom_range(0, 99) < vprob;
    bus.in_data = pix(in_frame, in_k);
    bus.out_ready = $urandom_range(0, 99) < rprob;
    #1;
    if (prev_stall) begin
      chk("stall_valid", bus.out_valid, 1);
      chk("stall_data", bus.out_data, prev_data);
    end
    if (in_frame != out_frame) chk("drain_in_ready", bus.in_ready, 0);
    if (after_last) chk("next_frame_ready", bus.in_ready, 1);
    after_last = 1'b0;
    if (bus.out_valid && !seen_first) begin
      if (chk_first) chk("first_valid_px", in_k, 7);
      seen_first = 1'b1;
    end
    ih = bus.in_valid && bus.in_ready;
    oh = bus.out_valid && bus.out_ready;
    if (oh) begin
      chk($sformatf("win_f%0d_w%0d", out_frame, out_w), bus.out_data, gold(out_frame, out_w));
      chk($sformatf("last_f%0d_w%0d", out_frame, out_w), bus.out_last, out_w == NW - 1);
      if (out_frame == cap_frame) begin
        got_win[out_w] = bus.out_data;
        got_last[out_w] = bus.out_last;
      end
      out_w++;
      if (out_w == NW) begin
        out_w = 0;
        out_frame++;
        frames_done++;
        after_last = 1'b1;
        seen_first = 1'b0;
      end
    end
    if (ih) begin
      in_k++;
      if (in_k == NW) begin
        in_k = 0;
        in_frame++;
      end
    end
    pend = bus.in_valid && !ih;
    prev_stall = bus.out_valid && !bus.out_ready;
    prev_data = bus.out_data;
  endtask

  task automatic do_reset();
    int nf;
    @(negedge clk);
    res_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_last", bus.out_last, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    res_n = 1'b1;
    nf = (in_frame > out_frame ? in_frame : out_frame) + 1;
    in_frame = nf;
    out_frame = nf;
    in_k = 0;
    out_w = 0;
    pend = 1'b0;
    prev_stall = 1'b0;
    after_last = 1'b0;
    seen_first = 1'b0;
  endtask

  task automatic run_frames(input int n, input int budget);
    int target;
    target = frames_done + n;
    for (int t = 0; t < budget && frames_done < target; t++) step();
    chk("frame_timeout", frames_done >= target, 1);
  endtask

  initial begin
    int f0;
    void'($urandom(32'd7));
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b0;
    tbl[0] = '{0, w9(0, 0, 0, 0, 1, 2, 0, 5, 6), 1'b0};
    tbl[1] = '{3, w9(0, 0, 0, 3, 4, 0, 7, 8, 0), 1'b0};
    tbl[2] = '{5, w9(1, 2, 3, 5, 6, 7, 9, 10, 11), 1'b0};
    tbl[3] = '{12, w9(0, 9, 10, 0, 13, 14, 0, 0, 0), 1'b0};
    tbl[4] = '{15, w9(11, 12, 0, 15, 16, 0, 0, 0, 0), 1'b1};
    // free flow, two back-to-back frames; frame 0 captured for the table
    do_reset();
    cap_frame = 0;
    vprob = 100;
    rprob = 100;
    chk_first = 1'b1;
    run_frames(2, 200);
    for (int t = 0; t < 5; t++) begin
      chk($sformatf("tbl_win%0d", tbl[t].idx), got_win[tbl[t].idx], tbl[t].win);
      chk($sformatf("tbl_last%0d", tbl[t].idx), got_last[tbl[t].idx], tbl[t].last);
    end
    cap_frame = -1;
    // downstream stalled for the whole frame, then released
    do_reset();
    rprob = 0;
    repeat (30) step();
    chk("stall_px", in_k, 12);
    chk("stall_in_ready", bus.in_ready, 0);
    chk("stall_hold_valid", bus.out_valid, 1);
    chk("stall_hold_win0", bus.out_data, gold(out_frame, 0));
    rprob = 100;
    run_frames(1, 200);
    // random toggling over several frames
    chk_first = 1'b0;
    vprob = 60;
    rprob = 60;
    f0 = frames_done;
    repeat (1000) step();
    chk("random_frames", (frames_done - f0) >= 3, 1);
    vprob = 100;
    rprob = 100;
    run_frames(1, 200);
    // reset mid-frame after 7 pixels and window 0 loaded
    do_reset();
    chk_first = 1'b1;
    for (int t = 0; t < 50 && in_k < 7; t++) step();
    chk("pre_reset_px", in_k, 7);
    do_reset();
    run_frames(1, 200);
    // reset while a window is held in the stalled output slot
    do_reset();
    rprob = 0;
    repeat (15) step();
    chk("pre_reset_stall_valid", bus.out_valid, 1);
    do_reset();
    rprob = 100;
    run_frames(1, 200);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end
endmodule
